// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions: FSM states, extended-datapath widths, GRS bit positions.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fsm_state_t;

  // Positions of guard/round/sticky at the bottom of the extended datapath
  // {carry, significand, G, R, S}.
  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

  // Extended datapath width: carry + significand + G/R/S.
  function automatic int ext_w(input int sig_w);
    return sig_w + 4;
  endfunction

  // Width of shift amounts and leading-zero counts over the extended datapath.
  function automatic int sh_w(input int sig_w);
    return $clog2(sig_w + 4);
  endfunction

endpackage

// File: rtl/fadd_sub_pipe_if.sv
// Handshake bundle between the operand unpacker, fadd_sub_pipe and the result packer.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request side and the result side.
// Modports: slave = the adder (consumes requests, produces results);
//           master = the environment (drives requests, consumes results).
interface fadd_sub_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int SIG_W = FRAC_W + 1;

  logic              faddsub_valid_i;
  logic              faddsub_ready_o;
  logic              faddsub_op_i;
  logic              faddsub_sign1_i;
  logic              faddsub_sign2_i;
  logic [EXP_W-1:0]  faddsub_exp1_i;
  logic [EXP_W-1:0]  faddsub_exp2_i;
  logic [SIG_W-1:0]  faddsub_scfnd1_i;
  logic [SIG_W-1:0]  faddsub_scfnd2_i;
  logic              faddsub_valid_o;
  logic              faddsub_ready_i;
  logic              faddsub_sign_o;
  logic [EXP_W-1:0]  faddsub_exp_o;
  logic [FRAC_W-1:0] faddsub_frac_o;
  logic [2:0]        faddsub_grs_o;
  logic              faddsub_ovf_o;
  logic              faddsub_zero_o;

  modport slave (
    input  faddsub_valid_i, faddsub_op_i, faddsub_sign1_i, faddsub_sign2_i,
           faddsub_exp1_i, faddsub_exp2_i, faddsub_scfnd1_i, faddsub_scfnd2_i,
           faddsub_ready_i,
    output faddsub_ready_o, faddsub_valid_o, faddsub_sign_o, faddsub_exp_o,
           faddsub_frac_o, faddsub_grs_o, faddsub_ovf_o, faddsub_zero_o
  );

  modport master (
    output faddsub_valid_i, faddsub_op_i, faddsub_sign1_i, faddsub_sign2_i,
           faddsub_exp1_i, faddsub_exp2_i, faddsub_scfnd1_i, faddsub_scfnd2_i,
           faddsub_ready_i,
    input  faddsub_ready_o, faddsub_valid_o, faddsub_sign_o, faddsub_exp_o,
           faddsub_frac_o, faddsub_grs_o, faddsub_ovf_o, faddsub_zero_o
  );

endinterface

// File: rtl/fpu_lzc.sv
// Leading-zero counter with all-zero flag, shared by the add/sub and multiply normalisers.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: din (W bits, MSB first), cnt (leading zeros, W when din is zero), all_zero.
module fpu_lzc #(
  parameter int W     = 27,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] cnt,
  output logic             all_zero
);

  always_comb begin
    cnt      = CNT_W'(W);
    all_zero = (din == '0);
    // Scan upward so the highest set bit has the final say.
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_sub_pipe.sv
// Multi-cycle unpacked floating-point add/subtract (IDLE-ALIGN-ADD-NORM-[ROUND]-DONE), one op in flight.
// Latency: result valid in the 4th cycle after acceptance (5th with FADDSUB_ROUND_EN); issue interval latency+1.
// Backpressure: DONE holds registered outputs stable until ready; ready is low from ALIGN through DONE.
// Ports: fpu_clk, fpu_rst (synchronous, active-high), bus (fadd_sub_pipe_if.slave: request
//        operands/op with valid/ready, result sign/exp/frac/grs/ovf/zero with valid/ready).
// Option: define FADDSUB_ROUND_EN for in-block round-to-nearest-even (grs driven 0); otherwise
//         frac is truncated and grs carries the raw guard/round/sticky bits.
module fadd_sub_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input logic            fpu_clk,
  input logic            fpu_rst,
  fadd_sub_pipe_if.slave bus
);

  localparam int SIG_W = FRAC_W + 1;
  localparam int EXT_W = ext_w(SIG_W);
  localparam int SH_W  = sh_w(SIG_W);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  fsm_state_t        state;
  logic              op_q, s1_q, s2_q;
  logic [EXP_W-1:0]  e1_q, e2_q;
  logic [SIG_W-1:0]  m1_q, m2_q;
  logic              sign_big_q, sign_small_q;
  logic [EXP_W-1:0]  exp_q;
  logic [EXT_W-1:0]  big_q, small_q, sum_q;

  logic              ready_q, res_valid, res_sign, res_ovf, res_zero;
  logic [EXP_W-1:0]  res_exp;
  logic [FRAC_W-1:0] res_frac;
  logic [2:0]        res_grs;

  // ---------------- alignment ----------------
  logic [EXP_W-1:0]   ee1, ee2, eb, es, dexp;
  logic [SIG_W-1:0]   mb, ms;
  logic               sb, ss;
  logic [SH_W-1:0]    dsh;
  logic [2*EXT_W-1:0] wide;
  logic [EXT_W-1:0]   a_big, a_small;

  always_comb begin
    // Subnormals live at the same scale as exponent 1.
    ee1 = (e1_q == '0) ? EXP_W'(1) : e1_q;
    ee2 = (e2_q == '0) ? EXP_W'(1) : e2_q;
    if ({ee1, m1_q} >= {ee2, m2_q}) begin
      eb = ee1; mb = m1_q; sb = s1_q;
      es = ee2; ms = m2_q; ss = s2_q ^ op_q;
    end else begin
      eb = ee2; mb = m2_q; sb = s2_q ^ op_q;
      es = ee1; ms = m1_q; ss = s1_q;
    end
    dexp = eb - es;
    // Beyond SIG_W+2 the whole significand already sits in sticky.
    dsh  = (32'(dexp) > 32'(SIG_W + 2)) ? SH_W'(SIG_W + 2) : SH_W'(dexp);
    // Shift into a double-width window; the lower half holds everything lost.
    wide    = {1'b0, ms, 3'b000, {EXT_W{1'b0}}} >> dsh;
    a_small = wide[2*EXT_W-1:EXT_W] | EXT_W'(|wide[EXT_W-1:0]);
    a_big   = {1'b0, mb, 3'b000};
  end

  // ---------------- magnitude add/subtract ----------------
  logic [EXT_W-1:0] sum_d;
  assign sum_d = (sign_big_q ^ sign_small_q) ? (big_q - small_q) : (big_q + small_q);

  // ---------------- normalisation ----------------
  logic [SH_W-1:0]  lz;
  logic             lz_zero;
  logic [EXT_W-1:0] n_ext;
  logic [EXP_W-1:0] n_exp;
  logic             n_sign, n_ovf, n_zero;

  fpu_lzc #(.W(EXT_W - 1), .CNT_W(SH_W)) u_lzc (
    .din      (sum_q[EXT_W-2:0]),
    .cnt      (lz),
    .all_zero (lz_zero)
  );

  always_comb begin
    n_ext  = sum_q;
    n_exp  = exp_q;
    n_sign = sign_big_q;
    n_ovf  = 1'b0;
    n_zero = 1'b0;
    if (sum_q[EXT_W-1]) begin
      // Carry out: fold the dropped bit into sticky.
      n_ext = {1'b0, sum_q[EXT_W-1:2], sum_q[1] | sum_q[0]};
      n_exp = exp_q + EXP_W'(1);
      if (n_exp == EXP_ONES) begin
        n_ovf = 1'b1;
        n_ext = '0;
      end
    end else if (lz_zero) begin
      n_zero = 1'b1;
      n_sign = 1'b0;
      n_exp  = '0;
      n_ext  = '0;
    end else if (32'(exp_q) > 32'(lz)) begin
      n_ext = sum_q << lz;
      n_exp = exp_q - EXP_W'(lz);
    end else begin
      // Not enough exponent range to normalise fully: result is subnormal.
      n_ext = sum_q << (exp_q - EXP_W'(1));
      n_exp = '0;
    end
  end

`ifdef FADDSUB_ROUND_EN
  // ---------------- round to nearest even ----------------
  logic             nrm_ovf, nrm_zero;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W:0]   r_sum;
  logic             r_inc, r_ovf;
  logic [EXP_W-1:0] r_exp;
  logic [FRAC_W-1:0] r_frac;

  always_comb begin
    r_sig  = sum_q[EXT_W-2:3];
    r_inc  = sum_q[GRS_G] & (sum_q[GRS_R] | sum_q[GRS_S] | r_sig[0]) & ~nrm_ovf;
    r_sum  = {1'b0, r_sig} + {{SIG_W{1'b0}}, r_inc};
    r_exp  = exp_q;
    r_frac = r_sum[FRAC_W-1:0];
    r_ovf  = nrm_ovf;
    if (r_sum[SIG_W]) begin
      r_exp  = exp_q + EXP_W'(1);
      r_frac = '0;
      if (r_exp == EXP_ONES) r_ovf = 1'b1;
    end else if (exp_q == '0 && r_sum[SIG_W-1]) begin
      // Subnormal rounded up into the smallest normal.
      r_exp = EXP_W'(1);
    end
  end
`endif

  // ---------------- control and registers ----------------
  always_ff @(posedge fpu_clk) begin
    if (fpu_rst) begin
      state     <= ST_IDLE;
      ready_q   <= 1'b1;
      res_valid <= 1'b0;
      res_sign  <= 1'b0;
      res_exp   <= '0;
      res_frac  <= '0;
      res_grs   <= '0;
      res_ovf   <= 1'b0;
      res_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.faddsub_valid_i) begin
            op_q    <= bus.faddsub_op_i;
            s1_q    <= bus.faddsub_sign1_i;
            s2_q    <= bus.faddsub_sign2_i;
            e1_q    <= bus.faddsub_exp1_i;
            e2_q    <= bus.faddsub_exp2_i;
            m1_q    <= bus.faddsub_scfnd1_i;
            m2_q    <= bus.faddsub_scfnd2_i;
            ready_q <= 1'b0;
            state   <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          big_q        <= a_big;
          small_q      <= a_small;
          exp_q        <= eb;
          sign_big_q   <= sb;
          sign_small_q <= ss;
          state        <= ST_ADD;
        end
        ST_ADD: begin
          sum_q <= sum_d;
          state <= ST_NORM;
        end
        ST_NORM: begin
`ifdef FADDSUB_ROUND_EN
          sum_q      <= n_ext;
          exp_q      <= n_exp;
          sign_big_q <= n_sign;
          nrm_ovf    <= n_ovf;
          nrm_zero   <= n_zero;
          state      <= ST_ROUND;
`else
          res_sign  <= n_sign;
          res_exp   <= n_exp;
          res_frac  <= n_ext[EXT_W-3:3];
          res_grs   <= n_ext[2:0];
          res_ovf   <= n_ovf;
          res_zero  <= n_zero;
          res_valid <= 1'b1;
          state     <= ST_DONE;
`endif
        end
`ifdef FADDSUB_ROUND_EN
        ST_ROUND: begin
          res_sign  <= sign_big_q;
          res_exp   <= r_exp;
          res_frac  <= r_frac;
          res_grs   <= '0;
          res_ovf   <= r_ovf;
          res_zero  <= nrm_zero;
          res_valid <= 1'b1;
          state     <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (bus.faddsub_ready_i) begin
            res_valid <= 1'b0;
            res_sign  <= 1'b0;
            res_exp   <= '0;
            res_frac  <= '0;
            res_grs   <= '0;
            res_ovf   <= 1'b0;
            res_zero  <= 1'b0;
            ready_q   <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.faddsub_ready_o = ready_q;
  assign bus.faddsub_valid_o = res_valid;
  assign bus.faddsub_sign_o  = res_sign;
  assign bus.faddsub_exp_o   = res_exp;
  assign bus.faddsub_frac_o  = res_frac;
  assign bus.faddsub_grs_o   = res_grs;
  assign bus.faddsub_ovf_o   = res_ovf;
  assign bus.faddsub_zero_o  = res_zero;

endmodule
